sqrt_iter_unit: RTL and testbench

- Sequential integer square-root engine for the square-root finder datapath.
- Takes an unsigned WIDTH-bit radicand from the operand-entry logic.
- Produces the truncated root (WIDTH/2 bits) and the remainder.
- The root feeds the downstream 8-bit binary-to-BCD display stage directly, so the root port is 8 bits wide at default WIDTH.
- Uses the restoring digit-by-digit algorithm: one root bit per clock, with a start/busy/done handshake.

---
 rtl/sqrt_iter_unit.sv | 128 ++++++++++++
 tb/tb_sqrt_iter_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_unit.sv
// sqrt_iter_unit: sequential restoring square-root engine, one root bit per clock.
// Produces floor(sqrt(radicand)) and the remainder radicand - root^2.
// Optional build macro SQRT_ROUND_EN: the root output is rounded to nearest
// (saturating at the maximum root value); the remainder stays truncated.
//
// Handshake: start is sampled only while idle (busy=0); the edge that accepts it
// captures radicand and raises busy. busy stays high for WIDTH/2 cycles, and the
// edge that finishes the last iteration drops busy, updates root/remainder and
// raises done for exactly one cycle. start during busy is ignored. start in the
// done cycle is accepted, since the engine is already idle. root/remainder hold
// their value until the next completion or reset.
module sqrt_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     remainder,
  output logic                 dbg_state
);

  localparam int RW  = WIDTH / 2;
  localparam int RMW = RW + 1;
  localparam int CW  = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [RW-1:0]      proot_q;
  logic [RW+1:0]      rem_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [RW-1:0]      root_q;
  logic [RW:0]        remainder_q;

  logic [RW+1:0]      rem_t;
  logic [RW+1:0]      trial;
  logic               take;
  logic [RW+1:0]      rem_d;
  logic [RW-1:0]      proot_d;
  logic [WIDTH-1:0]   shreg_d;
  logic [CW-1:0]      cnt_d;
  logic               last_iter;
  logic [RW-1:0]      root_d;
  logic [RW:0]        remainder_d;

  // One restoring iteration: bring down two radicand bits and try to subtract.
  always_comb begin
    rem_t       = (rem_q << 2) | {{RW{1'b0}}, shreg_q[WIDTH-1 -: 2]};
    trial       = {proot_q, 2'b01};
    take        = (rem_t >= trial);
    rem_d       = take ? (rem_t - trial) : rem_t;
    proot_d     = (proot_q << 1) | {{(RW-1){1'b0}}, take};
    shreg_d     = shreg_q << 2;
    cnt_d       = cnt_q + CW'(1);
    last_iter   = (cnt_q == CW'(RW - 1));
    remainder_d = RMW'(rem_d);
`ifdef SQRT_ROUND_EN
    // Round up when the remainder exceeds the truncated root, unless saturated.
    if ((rem_d > {2'b00, proot_d}) && !(&proot_d)) begin
      root_d = proot_d + RW'(1);
    end else begin
      root_d = proot_d;
    end
`else
    root_d = proot_d;
`endif
  end

  // Control FSM and datapath registers; idle waits for start, run iterates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      proot_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      root_q      <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shreg_q <= radicand;
            proot_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          shreg_q <= shreg_d;
          proot_q <= proot_d;
          rem_q   <= rem_d;
          cnt_q   <= cnt_d;
          if (last_iter) begin
            root_q      <= root_d;
            remainder_q <= remainder_d;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign root      = root_q;
  assign remainder = remainder_q;
  assign dbg_state = (state_q == S_RUN);

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// tb_sqrt_iter_unit: randomized and directed bench for sqrt_iter_unit, checked
// against an arithmetic square-root model with a result queue.
module tb_sqrt_iter_unit;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;
  localparam int EW    = RW + RW + 1;
  localparam int XMAX  = (1 << WIDTH) - 1;
  localparam int RMAX  = (1 << RW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] radicand;
  logic             busy;
  logic             done;
  logic [RW-1:0]    root;
  logic [RW:0]      remainder;
  logic             dbg_state;

  int compared   = 0;
  int mismatched = 0;

  sqrt_iter_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .radicand  (radicand),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int ref_root(input int x);
    int r;
    r = isqrt(x);
`ifdef SQRT_ROUND_EN
    if ((x - r * r) > r && r < RMAX) r++;
`endif
    return r;
  endfunction

  function automatic logic [EW-1:0] pack(input int x);
    int t;
    int r;
    t = isqrt(x);
    r = ref_root(x);
    return {RW'(r), (RW+1)'(x - t * t)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected {root, remainder} pushed at acceptance, popped at completion.
  logic [EW-1:0] exp_q[$];
  logic          m_valid = 1'b0;
  logic          m_busy;
  logic          m_done;
  int            m_root;
  int            m_rem;
  int            m_cnt;

  always @(posedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_root  <= 0;
      m_rem   <= 0;
      m_cnt   <= 0;
      exp_q.delete();
    end else if (m_valid) begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard: got empty queue expected one entry");
          end else begin
            e = exp_q.pop_front();
            m_root <= int'(e[EW-1 -: RW]);
            m_rem  <= int'(e[RW:0]);
          end
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= RW;
        exp_q.push_back(pack(int'(radicand)));
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("root", int'(root), m_root);
      chk("remainder", int'(remainder), m_rem);
      chk("dbg_state", int'(dbg_state), int'(m_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 4 * RW) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int x, output int r, output int rm, output int lat);
    @(negedge clk);
    start    = 1'b1;
    radicand = WIDTH'(x);
    @(negedge clk);
    start    = 1'b0;
    radicand = WIDTH'($urandom_range(0, XMAX));
    wait_done(lat);
    r  = int'(root);
    rm = int'(remainder);
  endtask

  // ---------------- directed + random stimulus ----------------
  int lit_x[7]    = '{144, 200, 0, 1, 65535, 210, 211};
`ifdef SQRT_ROUND_EN
  int lit_root[7] = '{12, 14, 0, 1, 255, 14, 15};
`else
  int lit_root[7] = '{12, 14, 0, 1, 255, 14, 14};
`endif
  int lit_rem[7]  = '{0, 4, 0, 0, 510, 14, 15};

  initial begin
    int r, rm, lat, lat2, n, x, cur;
    rst_n    = 1'b0;
    start    = 1'b0;
    radicand = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: everything stays at zero.
    repeat (6) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_root", int'(root), 0);
    chk("idle_rem", int'(remainder), 0);

    // Pin the model itself against hand-computed values.
    for (int i = 0; i < 7; i++) begin
      chk("model_root", ref_root(lit_x[i]), lit_root[i]);
      chk("model_rem", lit_x[i] - isqrt(lit_x[i]) * isqrt(lit_x[i]), lit_rem[i]);
    end

    // Basic, boundary and rounding operands.
    for (int i = 0; i < 7; i++) begin
      run_op(lit_x[i], r, rm, lat);
      chk("lit_latency", lat, RW);
      chk("lit_root", r, lit_root[i]);
      chk("lit_rem", rm, lit_rem[i]);
      repeat (2) @(negedge clk);
    end

    // start while busy is ignored.
    @(negedge clk);
    start = 1'b1; radicand = WIDTH'(200);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 4 * RW) begin
      @(negedge clk);
      lat++;
      start = (lat == 3);
      if (lat == 3) radicand = WIDTH'(144);
    end
    start = 1'b0;
    chk("ign_latency", lat, RW);
    chk("ign_root", int'(root), 14);
    chk("ign_rem", int'(remainder), 4);
    n = 0;
    repeat (2 * RW) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("ign_extra_done", n, 0);

    // start in the done cycle is accepted back-to-back.
    @(negedge clk);
    start = 1'b1; radicand = WIDTH'(200);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("b2b_first_root", int'(root), 14);
    start = 1'b1; radicand = WIDTH'(144);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat2);
    chk("b2b_gap", lat2 + 1, RW + 1);
    chk("b2b_second_root", int'(root), 12);
    chk("b2b_second_rem", int'(remainder), 0);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; radicand = WIDTH'(65535);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_root", int'(root), 0);
    chk("abort_rem", int'(remainder), 0);
    rst_n = 1'b1;
    n = 0;
    repeat (3 * RW) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);

    // Randomized back-to-back sweep.
    cur = $urandom_range(0, XMAX);
    @(negedge clk);
    start = 1'b1; radicand = WIDTH'(cur);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = 1'b0;
      radicand = WIDTH'($urandom_range(0, XMAX));
      wait_done(lat);
      r  = int'(root);
      rm = int'(remainder);
`ifndef SQRT_ROUND_EN
      chk("rand_bounds", int'((r * r <= cur) && ((r + 1) * (r + 1) > cur)), 1);
      chk("rand_rem_identity", rm, cur - r * r);
`endif
      if (i < 1999) begin
        x = $urandom_range(0, XMAX);
        cur = x;
        start = 1'b1;
        radicand = WIDTH'(x);
      end
    end
    repeat (2 * RW) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
